// File: rtl/rgb_pwm_fader_pkg.sv
// Shared definitions for the RGB PWM fader: colour bit positions in the
// {R,G,B} code, the fade FSM state type and a counter-width helper.
package rgb_pwm_fader_pkg;

    // Bit positions of each colour inside color_in / led.
    localparam int CH_R   = 2;
    localparam int CH_G   = 1;
    localparam int CH_B   = 0;
    localparam int NUM_CH = 3;

    // Fade sequencing state: IDLE when every level sits on its target.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_FADING = 1'b1
    } fade_state_e;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_pwm_fader_pwm_channel.sv
// One LED channel: the brightness level that walks one step per fade tick
// toward its target, the compare value latched at each PWM period boundary
// and the registered pin drive.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] target_i,
    input  logic                fade_tick_i,
    input  logic                period_start_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o,
    output logic                at_target_o
);

    localparam logic [PWM_BITS-1:0] FULL_ON = '1;
    localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] cmp_q, cmp_d;
    logic                led_q, led_d;

    // Fade stepper: move one unit toward the target, never past it, so the
    // level cannot wrap at either end of its range.
    always_comb begin
        level_d = level_q;
        if (fade_tick_i) begin
            if (level_q < target_i) begin
                level_d = level_q + ONE;
            end else if (level_q > target_i) begin
                level_d = level_q - ONE;
            end
        end
    end

    // Compare value only changes at the period boundary, so a duty change can
    // never cut or stretch a pulse that is already running. When a fade step
    // lands on the same edge, the pre-step level is the one captured.
    always_comb begin
        cmp_d = period_start_i ? level_q : cmp_q;
    end

    // Pin compare: the top code is forced full-on, otherwise high while the
    // PWM counter is below the compare value (zero gives a dark pin).
    always_comb begin
        led_d = (cmp_q == FULL_ON) || (pwm_cnt_i < cmp_q);
    end

    // Channel state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            cmp_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            cmp_q   <= cmp_d;
            led_q   <= led_d;
        end
    end

    assign led_o       = led_q;
    assign at_target_o = (level_q == target_i);

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB PWM fader top: captures the colour code and brightness, runs the PWM
// prescaler/counter and the fade-step timer, sequences the fading flag and
// drives three pwm_channel instances.
module rgb_pwm_fader
    import rgb_pwm_fader_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int PWM_DIV  = 16,
    parameter int FADE_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          color_in,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [2:0]          led,
    output logic                fading
);

    localparam int PRE_W  = cnt_width(PWM_DIV);
    localparam int FADE_W = cnt_width(FADE_DIV);

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PWM_DIV - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
    localparam logic [FADE_W-1:0]   FADE_LAST = FADE_W'(FADE_DIV - 1);
    localparam logic [FADE_W-1:0]   FADE_ONE  = FADE_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    logic [2:0]          color_q;
    logic [PWM_BITS-1:0] bright_q;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FADE_W-1:0]   fade_q, fade_d;
    fade_state_e         state_q, state_d;

    logic                pwm_tick;
    logic                period_start;
    logic                fade_tick;
    logic [PWM_BITS-1:0] target_r, target_g, target_b;
    logic                led_r, led_g, led_b;
    logic                at_r, at_g, at_b;
    logic                all_at_target;

    // Capture the level inputs once per clock; everything downstream works
    // from these registered copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q  <= '0;
            bright_q <= '0;
        end else begin
            color_q  <= color_in;
            bright_q <= brightness;
        end
    end

    // Per-channel targets follow the captured inputs every cycle.
    always_comb begin
        target_r = color_q[CH_R] ? bright_q : '0;
        target_g = color_q[CH_G] ? bright_q : '0;
        target_b = color_q[CH_B] ? bright_q : '0;
    end

    assign pwm_tick     = (pre_q == PRE_LAST);
    assign period_start = pwm_tick && (pwm_cnt_q == PWM_LAST);
    assign fade_tick    = (fade_q == FADE_LAST);

    // Next values for the prescaler, PWM counter and fade timer.
    always_comb begin
        pre_d     = pwm_tick ? '0 : pre_q + PRE_ONE;
        pwm_cnt_d = pwm_tick ? pwm_cnt_q + PWM_ONE : pwm_cnt_q;
        fade_d    = fade_tick ? '0 : fade_q + FADE_ONE;
    end

    // Timebase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            fade_q    <= '0;
        end else begin
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            fade_q    <= fade_d;
        end
    end

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
        .clk            (clk),
        .rst_n          (rst_n),
        .target_i       (target_r),
        .fade_tick_i    (fade_tick),
        .period_start_i (period_start),
        .pwm_cnt_i      (pwm_cnt_q),
        .led_o          (led_r),
        .at_target_o    (at_r)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
        .clk            (clk),
        .rst_n          (rst_n),
        .target_i       (target_g),
        .fade_tick_i    (fade_tick),
        .period_start_i (period_start),
        .pwm_cnt_i      (pwm_cnt_q),
        .led_o          (led_g),
        .at_target_o    (at_g)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .target_i       (target_b),
        .fade_tick_i    (fade_tick),
        .period_start_i (period_start),
        .pwm_cnt_i      (pwm_cnt_q),
        .led_o          (led_b),
        .at_target_o    (at_b)
    );

    assign all_at_target = at_r && at_g && at_b;

    // Fade FSM next state: leave IDLE on any mismatch, return once the
    // step that closes the last gap has landed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!all_at_target) state_d = ST_FADING;
            ST_FADING: if (all_at_target)  state_d = ST_IDLE;
        endcase
    end

    // Fade FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign fading = (state_q == ST_FADING);

    always_comb begin
        led       = '0;
        led[CH_R] = led_r;
        led[CH_G] = led_g;
        led[CH_B] = led_b;
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with PWM_BITS=4, PWM_DIV=2, FADE_DIV=4:
// one PWM period is 32 clocks, one fade step every 4 clocks. Cycle n is the
// n-th rising edge after reset release; outputs are sampled on the falling
// edge that follows it.
module tb_rgb_pwm_fader;

    localparam int PWM_BITS = 4;
    localparam int PWM_DIV  = 2;
    localparam int FADE_DIV = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [2:0]          color_in = '0;
    logic [PWM_BITS-1:0] brightness = '0;
    logic [2:0]          led;
    logic                fading;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int h2, h1, h0;
    int at_cyc;
    int prev_lvl, cur_lvl, bad_steps;

    rgb_pwm_fader #(
        .PWM_BITS (PWM_BITS),
        .PWM_DIV  (PWM_DIV),
        .FADE_DIV (FADE_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .color_in   (color_in),
        .brightness (brightness),
        .led        (led),
        .fading     (fading)
    );

    // Clock: 10 time-unit period, first rising edge at t=5.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one rising edge and park on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Hold reset for two cycles with the given inputs, release on a falling edge.
    task automatic apply_reset(input logic [2:0] c, input logic [PWM_BITS-1:0] b);
        rst_n      = 1'b0;
        color_in   = c;
        brightness = b;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic count_leds(input int n, output int c2, output int c1, output int c0);
        c2 = 0;
        c1 = 0;
        c0 = 0;
        repeat (n) begin
            tick();
            if (led[2]) c2++;
            if (led[1]) c1++;
            if (led[0]) c0++;
        end
    endtask

    // Wait for fading to drop, bounded; the returned cycle is the bound on timeout.
    task automatic wait_idle(input int limit, output int when);
        while (fading && cyc < limit) tick();
        when = cyc;
    endtask

    initial begin
        // Asynchronous reset with no clock edge involved.
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset_led", 32'(led), 0);
        check_eq("reset_fading", 32'(fading), 0);

        // Full-brightness red fade-in: 15 steps at edges 4,8,..,60.
        apply_reset(3'b100, 4'd15);
        tick();
        check_eq("t1_fading_c1", 32'(fading), 0);
        tick();
        check_eq("t1_fading_c2", 32'(fading), 1);
        run_to(8);
        check_eq("t1_level_c8", 32'(dut.u_ch_r.level_q), 2);
        run_to(9);
        wait_idle(200, at_cyc);
        check_eq("t1_idle_cycle", 32'(at_cyc), 61);
        check_eq("t1_level_final", 32'(dut.u_ch_r.level_q), 15);
        run_to(65);
        count_leds(64, h2, h1, h0);
        check_eq("t1_red_full_on", 32'(h2), 64);
        check_eq("t1_green_off", 32'(h1), 0);
        check_eq("t1_blue_off", 32'(h0), 0);

        // Fade step lands on the PWM wrap at edge 32: old level 7 for one period.
        apply_reset(3'b100, 4'd8);
        run_to(32);
        check_eq("t6_level_c32", 32'(dut.u_ch_r.level_q), 8);
        check_eq("t6_cmp_c32", 32'(dut.u_ch_r.cmp_q), 7);
        count_leds(32, h2, h1, h0);
        check_eq("t6_width_old", 32'(h2), 14);
        count_leds(32, h2, h1, h0);
        check_eq("t6_width_new", 32'(h2), 16);

        // Green at brightness 4: dark first period, then 8 of 32 clocks lit.
        apply_reset(3'b010, 4'd4);
        count_leds(32, h2, h1, h0);
        check_eq("t2_first_period", 32'(h1), 0);
        count_leds(32, h2, h1, h0);
        check_eq("t2_period2_duty", 32'(h1), 8);
        count_leds(32, h2, h1, h0);
        check_eq("t2_period3_duty", 32'(h1), 8);
        check_eq("t2_red_off", 32'(h2), 0);
        check_eq("t2_blue_off", 32'(h0), 0);

        // Retarget to off at level 8: first down-step at edge 36, zero at 64.
        apply_reset(3'b100, 4'd15);
        run_to(32);
        check_eq("t3_level_c32", 32'(dut.u_ch_r.level_q), 8);
        color_in  = 3'b000;
        prev_lvl  = 8;
        bad_steps = 0;
        repeat (16) begin
            tick();
            cur_lvl = int'(dut.u_ch_r.level_q);
            if (cur_lvl > prev_lvl || prev_lvl - cur_lvl > 1) bad_steps++;
            prev_lvl = cur_lvl;
        end
        check_eq("t3_level_c48", 32'(dut.u_ch_r.level_q), 4);
        check_eq("t3_fading_c48", 32'(fading), 1);
        while (fading && cyc < 200) begin
            tick();
            cur_lvl = int'(dut.u_ch_r.level_q);
            if (cur_lvl > prev_lvl || prev_lvl - cur_lvl > 1) bad_steps++;
            prev_lvl = cur_lvl;
        end
        check_eq("t3_idle_cycle", 32'(cyc), 65);
        check_eq("t3_no_jump", 32'(bad_steps), 0);
        check_eq("t3_level_final", 32'(dut.u_ch_r.level_q), 0);

        // White settled at 10, then brightness 0: steps at 104..140.
        apply_reset(3'b111, 4'd10);
        run_to(68);
        count_leds(32, h2, h1, h0);
        check_eq("t4_duty_r", 32'(h2), 20);
        check_eq("t4_duty_g", 32'(h1), 20);
        check_eq("t4_duty_b", 32'(h0), 20);
        brightness = 4'd0;
        run_to(102);
        check_eq("t4_fading_c102", 32'(fading), 1);
        wait_idle(300, at_cyc);
        check_eq("t4_idle_cycle", 32'(at_cyc), 141);
        check_eq("t4_level_g", 32'(dut.u_ch_g.level_q), 0);
        run_to(161);
        count_leds(64, h2, h1, h0);
        check_eq("t4_dark_all", 32'(h2 + h1 + h0), 0);

        // Reset between clock edges mid-fade while the pins are lit.
        apply_reset(3'b111, 4'd15);
        run_to(40);
        check_eq("t5_led_before", 32'(led), 7);
        check_eq("t5_fading_before", 32'(fading), 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_led_async", 32'(led), 0);
        check_eq("t5_fading_async", 32'(fading), 0);
        check_eq("t5_level_async", 32'(dut.u_ch_r.level_q), 0);
        apply_reset(3'b111, 4'd15);
        run_to(3);
        check_eq("t5_restart_c3", 32'(dut.u_ch_b.level_q), 0);
        run_to(4);
        check_eq("t5_restart_c4", 32'(dut.u_ch_b.level_q), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
